aes_decrypt: RTL
================

AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
- REQ-001 SHALL have no parameters; the block is fixed AES-128, one round per clock.
- REQ-002 `clock` input 1: the single clock; all state updates on the rising edge.
- REQ-003 `reset` input 1: asynchronous, active-high; SHALL be asserted and released freely relative to `clock`.
- REQ-004 `we` input 1: start request, sampled on a rising edge.
- REQ-005 `ciphertext` input 128: block to decrypt; state byte k (FIPS-197 column-major order) at bits [8k+7:8k].
- REQ-006 `secret` input 128: cipher key, same byte packing as `ciphertext`.
- REQ-007 `plaintext` output 128: result register, same byte packing.
- REQ-008 `busy` output 1: high while an operation is in progress.
- REQ-009 `done` output 1: one-cycle pulse when `plaintext` holds a new result.

Function
- REQ-010 SHALL implement the FIPS-197 AES-128 inverse cipher: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns; the final round omits InvMixColumns.
- REQ-011 SHALL use a state machine with states IDLE, KEYEXP and DEC.
- REQ-012 IDLE with `we`=1 SHALL:
  - capture `ciphertext` into the data register;
  - capture `secret` into the key register;
  - clear the round counter;
  - go to KEYEXP.
- REQ-013 KEYEXP SHALL compute round keys rk1..rk10 forward, one per cycle, using Rcon 01,02,04,08,10,20,40,80,1b,36, over 10 cycles.
- REQ-014 On the edge that loads rk10, the data register SHALL be loaded with data ^ rk10, and the FSM SHALL go to DEC.
- REQ-015 DEC SHALL perform one inverse round per cycle for r = 9 down to 0, over 10 cycles.
  - It SHALL derive rk_r from rk_(r+1) on the fly with the inverse key schedule.
  - No round-key storage array SHALL exist.
- REQ-016 On the final DEC edge:
  - `plaintext` SHALL be loaded with the result;
  - `done` SHALL be 1 for exactly the following cycle;
  - the FSM SHALL return to IDLE.
- REQ-017 Latency:
  - `done`=1 and `plaintext` valid in the cycle after the 20th rising edge following the start edge;
  - `busy`=1 in every cycle from the start edge up to and including that final edge;
  - `busy`=0 in the `done` cycle.
- REQ-018 `we` while `busy`=1 SHALL be ignored; the running operation and its result SHALL be unaffected.
- REQ-019 `we` in the `done` cycle SHALL start a new operation (back-to-back throughput of 1 block per 21 cycles).
- REQ-020 `ciphertext` and `secret` SHALL be don't-care after the start edge.
- REQ-021 `plaintext` SHALL hold its value until the next completion; it is never updated mid-operation.
- REQ-022 The round counter SHALL never exceed 10; unused FSM encodings SHALL return to IDLE.

Reset
- REQ-023 `reset`=1 SHALL immediately force:
  - state IDLE;
  - counter 0;
  - `busy`=0, `done`=0;
  - `plaintext`=128'h0;
  - the key and data registers to 0.
- REQ-024 Reset mid-operation SHALL abort the operation with no `done` pulse. The first `we` after release SHALL behave as from power-up.

Configuration
- REQ-025 Macro `AES_DECRYPT_KEYCACHE_EN`, when defined, SHALL add a cached rk10 register, a cached-secret register and a cache-valid flag. These SHALL be cleared by reset and written at the end of each KEYEXP.
- REQ-026 With the macro defined, a start whose `secret` equals the cached secret while the cache is valid SHALL:
  - skip KEYEXP and apply data ^ cached rk10 on the start edge;
  - enter DEC directly;
  - give `done` in the cycle after the 10th edge following the start edge.
- REQ-027 Without the macro, no cache logic SHALL exist and every operation SHALL take the REQ-017 latency.

Verification
Vectors are given in FIPS byte order; the bench packs byte 0 into [7:0].
- REQ-028 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, `done` 20 edges after start.
- REQ-029 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- REQ-030 Start C.1, pulse `we` with the App. B inputs at edge 5 -> C.1 result unchanged, one `done` only; then start App. B in the `done` cycle -> App. B result 20 edges later.
- REQ-031 Start C.1, assert `reset` asynchronously between edges 12 and 13 -> `busy`, `done`, `plaintext` = 0 at once, no `done` pulse; a fresh start gives the correct C.1 result.
- REQ-032 `AES_DECRYPT_KEYCACHE_EN` defined:
  - C.1 twice back-to-back -> first `done` at edge 20, second at edge 10;
  - then App. B key -> `done` at edge 20.

Source files
------------

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 inverse cipher, one round per clock.
// Define AES_DECRYPT_KEYCACHE_EN to reuse rk10 when the key repeats.
module aes_decrypt (
  input  logic         clock,
  input  logic         reset,
  input  logic         we,
  input  logic [127:0] ciphertext,
  input  logic [127:0] secret,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d};

  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_t;

  state_t       state, nxt;
  logic [3:0]   cnt;
  logic [127:0] key, data;
  logic [127:0] key_fwd, key_inv, round_out;
  logic         hit;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2040 - 8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] isb(input logic [7:0] b);
    return ISBOX[2040 - 8*int'(b) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return RCON[72 - 8*int'(i) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a,
                                     input logic [3:0] m);
    logic [7:0] a2, a4, a8;
    a2 = xt(a);
    a4 = xt(a2);
    a8 = xt(a4);
    return (m[0] ? a  : 8'h00) ^ (m[1] ? a2 : 8'h00)
         ^ (m[2] ? a4 : 8'h00) ^ (m[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = c;
    return {mul(a0, 4'hb) ^ mul(a1, 4'hd) ^ mul(a2, 4'h9) ^ mul(a3, 4'he),
            mul(a0, 4'hd) ^ mul(a1, 4'h9) ^ mul(a2, 4'he) ^ mul(a3, 4'hb),
            mul(a0, 4'h9) ^ mul(a1, 4'he) ^ mul(a2, 4'hb) ^ mul(a3, 4'hd),
            mul(a0, 4'he) ^ mul(a1, 4'hb) ^ mul(a2, 4'hd) ^ mul(a3, 4'h9)};
  endfunction

  // SubWord(RotWord(w)) ^ Rcon; byte 0 of a word sits in bits [7:0]
  function automatic logic [31:0] sub_rot(input logic [31:0] w,
                                          input logic [7:0]  rc);
    logic [31:0] r;
    r = {w[7:0], w[31:8]};
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(r[8*i +: 8]);
    return r ^ {24'h0, rc};
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k,
                                            input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[31:0] ^ sub_rot(k[127:96], rc);
    w1 = k[63:32] ^ w0;
    w2 = k[95:64] ^ w1;
    w3 = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] key_prev(input logic [127:0] k,
                                            input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[127:96] ^ k[95:64];
    w2 = k[95:64] ^ k[63:32];
    w1 = k[63:32] ^ k[31:0];
    w0 = k[31:0] ^ sub_rot(w3, rc);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[32*c + 8*r +: 8] = isb(s[32*((c + 4 - r) % 4) + 8*r +: 8]);
    t = t ^ rk;
    if (!last)
      for (int c = 0; c < 4; c++) t[32*c +: 32] = imc(t[32*c +: 32]);
    return t;
  endfunction

  assign key_fwd   = key_next(key, rcon(cnt));
  assign key_inv   = key_prev(key, rcon(cnt));
  assign round_out = inv_round(data, key_inv, cnt == 4'd0);

`ifdef AES_DECRYPT_KEYCACHE_EN
  logic [127:0] c_rk, c_key;
  logic         c_ok;

  assign hit = c_ok && (secret == c_key);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_ok  <= 1'b0;
      c_rk  <= '0;
      c_key <= '0;
    end else if (state == IDLE && we && !hit) begin
      c_ok  <= 1'b0;
      c_key <= secret;
    end else if (state == KEYEXP && cnt == 4'd9) begin
      c_ok  <= 1'b1;
      c_rk  <= key_fwd;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (we) nxt = hit ? DEC : KEYEXP;
      end
      KEYEXP: if (cnt == 4'd9) nxt = DEC;
      DEC:    if (cnt == 4'd0) nxt = IDLE;
      default: begin
        busy = 1'b0;
        nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      key       <= '0;
      data      <= '0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (we) begin
          cnt  <= '0;
          key  <= secret;
          data <= ciphertext;
`ifdef AES_DECRYPT_KEYCACHE_EN
          if (hit) begin
            cnt  <= 4'd9;
            key  <= c_rk;
            data <= ciphertext ^ c_rk;
          end
`endif
        end
        KEYEXP: begin
          key <= key_fwd;
          if (cnt == 4'd9) data <= data ^ key_fwd;
          else             cnt  <= cnt + 4'd1;
        end
        DEC: begin
          key  <= key_inv;
          data <= round_out;
          if (cnt == 4'd0) begin
            plaintext <= round_out;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
